// File: rtl/rv_pkg.sv
// RV32I decode constants shared by the ID stage: ALU control bit indices,
// opcodes, operand-select encodings, immediate formats and the ID/EX payload.
package rv_pkg;

  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned ALU_W   = 10;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned REG_W   = 5;

  // alu_ctrl bit positions
  localparam int unsigned ALU_NEG       = 0;
  localparam int unsigned ALU_ADD_SUB   = 1;
  localparam int unsigned ALU_UNSIGNED  = 2;
  localparam int unsigned ALU_CMP       = 3;
  localparam int unsigned ALU_ARITH     = 4;
  localparam int unsigned ALU_SHL       = 5;
  localparam int unsigned ALU_SHR       = 6;
  localparam int unsigned ALU_XOR_OR    = 7;
  localparam int unsigned ALU_OR_AND    = 8;
  localparam int unsigned ALU_JALR_JAL  = 9;

  localparam logic [ALU_W-1:0] ALU_OP_ADD  = ALU_W'(1) << ALU_ADD_SUB;
  localparam logic [ALU_W-1:0] ALU_OP_SUB  = ALU_OP_ADD | (ALU_W'(1) << ALU_NEG);
  localparam logic [ALU_W-1:0] ALU_OP_SLT  = (ALU_W'(1) << ALU_NEG) | (ALU_W'(1) << ALU_CMP);
  localparam logic [ALU_W-1:0] ALU_OP_SLTU = ALU_OP_SLT | (ALU_W'(1) << ALU_UNSIGNED);
  localparam logic [ALU_W-1:0] ALU_OP_SLL  = ALU_W'(1) << ALU_SHL;
  localparam logic [ALU_W-1:0] ALU_OP_SRL  = ALU_W'(1) << ALU_SHR;
  localparam logic [ALU_W-1:0] ALU_OP_SRA  = ALU_OP_SRL | (ALU_W'(1) << ALU_ARITH);
  localparam logic [ALU_W-1:0] ALU_OP_XOR  = ALU_W'(1) << ALU_XOR_OR;
  localparam logic [ALU_W-1:0] ALU_OP_AND  = ALU_W'(1) << ALU_OR_AND;
  localparam logic [ALU_W-1:0] ALU_OP_OR   = ALU_OP_XOR | ALU_OP_AND;
  localparam logic [ALU_W-1:0] ALU_OP_JAL  = ALU_W'(1) << ALU_JALR_JAL;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [SEL_W-1:0] IN1_RS1  = 2'd0;
  localparam logic [SEL_W-1:0] IN1_PC   = 2'd1;
  localparam logic [SEL_W-1:0] IN1_ZERO = 2'd2;
  localparam logic [SEL_W-1:0] IN2_RS2  = 2'd0;
  localparam logic [SEL_W-1:0] IN2_IMM  = 2'd1;
  localparam logic [SEL_W-1:0] IN2_PC4  = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [ALU_W-1:0]   alu_ctrl;
    logic [SEL_W-1:0]   in1_sel;
    logic [SEL_W-1:0]   in2_sel;
    logic [RV_XLEN-1:0] imm;
    logic [RV_XLEN-1:0] pc;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic               rd_we;
    logic               illegal;
  } id_ex_t;

  function automatic logic [RV_XLEN-1:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:     gen_imm = {{20{i[31]}}, i[31:20]};
      IMM_SHAMT: gen_imm = {27'd0, i[24:20]};
      IMM_S:     gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:     gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:     gen_imm = {i[31:12], 12'd0};
      IMM_J:     gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:   gen_imm = '0;
    endcase
  endfunction

  // funct3 -> ALU op for OP / OP-IMM; alt selects SUB / SRA
  function automatic logic [ALU_W-1:0] op_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  op_alu = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  op_alu = ALU_OP_SLL;
      3'b010:  op_alu = ALU_OP_SLT;
      3'b011:  op_alu = ALU_OP_SLTU;
      3'b100:  op_alu = ALU_OP_XOR;
      3'b101:  op_alu = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  op_alu = ALU_OP_OR;
      default: op_alu = ALU_OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder: instruction word -> ALU control, operand
// selects, immediate and register indices.
module alu_ctrl_dec
  import rv_pkg::*;
(
  input  logic [31:0]        inst,
  output logic [ALU_W-1:0]   alu_ctrl_c,
  output logic [SEL_W-1:0]   in1_sel_c,
  output logic [SEL_W-1:0]   in2_sel_c,
  output logic [RV_XLEN-1:0] imm_c,
  output logic [REG_W-1:0]   rs1_c,
  output logic [REG_W-1:0]   rs2_c,
  output logic [REG_W-1:0]   rd_c,
  output logic               rd_we_c,
  output logic               illegal_c
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_ok;
  logic       writes;
  imm_fmt_e   fmt;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);
  assign rs1_c  = inst[19:15];
  assign rs2_c  = inst[24:20];
  assign rd_c   = inst[11:7];

  always_comb begin
    alu_ctrl_c = '0;
    in1_sel_c  = IN1_RS1;
    in2_sel_c  = IN2_RS2;
    fmt        = IMM_NONE;
    writes     = 1'b0;
    illegal_c  = 1'b0;

    case (opcode)
      OPC_LUI: begin
        alu_ctrl_c = ALU_OP_JAL;
        in2_sel_c  = IN2_IMM;
        fmt        = IMM_U;
        writes     = 1'b1;
      end
      OPC_AUIPC: begin
        alu_ctrl_c = ALU_OP_ADD;
        in1_sel_c  = IN1_PC;
        in2_sel_c  = IN2_IMM;
        fmt        = IMM_U;
        writes     = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        alu_ctrl_c = ALU_OP_JAL;
        in2_sel_c  = IN2_PC4;
        fmt        = (opcode == OPC_JAL) ? IMM_J : IMM_I;
        writes     = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        case (f3)
          3'b000, 3'b001: alu_ctrl_c = ALU_OP_XOR;
          3'b100, 3'b101: alu_ctrl_c = ALU_OP_SLT;
          3'b110, 3'b111: alu_ctrl_c = ALU_OP_SLTU;
          default:        illegal_c  = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        alu_ctrl_c = ALU_OP_ADD;
        in2_sel_c  = IN2_IMM;
        fmt        = (opcode == OPC_LOAD) ? IMM_I : IMM_S;
        writes     = (opcode == OPC_LOAD);
      end
      OPC_OP_IMM: begin
        in2_sel_c  = IN2_IMM;
        writes     = 1'b1;
        alu_ctrl_c = op_alu(f3, 1'b0);
        fmt        = IMM_I;
        // shifts carry shamt in the immediate field and funct7 in the top bits
        if (f3 == 3'b001) begin
          fmt       = IMM_SHAMT;
          illegal_c = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          fmt        = IMM_SHAMT;
          illegal_c  = !f7_ok;
          alu_ctrl_c = op_alu(f3, f7[5]);
        end
      end
      OPC_OP: begin
        writes     = 1'b1;
        alu_ctrl_c = op_alu(f3, f7[5]);
        illegal_c  = !f7_ok || (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
      end
      default: illegal_c = 1'b1;
    endcase

    if (inst[1:0] != 2'b11) illegal_c = 1'b1;

    if (illegal_c) begin
      alu_ctrl_c = '0;
      in1_sel_c  = IN1_RS1;
      in2_sel_c  = IN2_RS2;
      fmt        = IMM_NONE;
      writes     = 1'b0;
    end
  end

  assign imm_c   = gen_imm(inst, fmt);
  assign rd_we_c = writes && (rd_c != '0);

endmodule

// File: rtl/id_alu_ctrl_stage.sv
// ID stage: decodes RV32I into the ID/EX register with valid/ready handshake
// and flush. Define ID_ALU_CTRL_SKID_EN for a second (skid) entry with registered in_ready.
module id_alu_ctrl_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9:0]      out_alu_ctrl,
  output logic [1:0]      out_in1_sel,
  output logic [1:0]      out_in2_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);

  logic [ALU_W-1:0]   dec_alu;
  logic [SEL_W-1:0]   dec_in1, dec_in2;
  logic [RV_XLEN-1:0] dec_imm;
  logic [REG_W-1:0]   dec_rs1, dec_rs2, dec_rd;
  logic               dec_we, dec_ill;
  id_ex_t             dec;
  id_ex_t             main_q, main_d;
  logic               valid_q, valid_d;
  logic               accept;

  alu_ctrl_dec u_dec (
    .inst       (in_inst),
    .alu_ctrl_c (dec_alu),
    .in1_sel_c  (dec_in1),
    .in2_sel_c  (dec_in2),
    .imm_c      (dec_imm),
    .rs1_c      (dec_rs1),
    .rs2_c      (dec_rs2),
    .rd_c       (dec_rd),
    .rd_we_c    (dec_we),
    .illegal_c  (dec_ill)
  );

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = dec_alu;
    dec.in1_sel  = dec_in1;
    dec.in2_sel  = dec_in2;
    dec.imm      = dec_imm;
    dec.pc       = RV_XLEN'(in_pc);
    dec.rs1      = dec_rs1;
    dec.rs2      = dec_rs2;
    dec.rd       = dec_rd;
    dec.rd_we    = dec_we;
    dec.illegal  = dec_ill;
  end

  assign accept = in_valid && in_ready;

`ifdef ID_ALU_CTRL_SKID_EN
  id_ex_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  // skid drains first to keep order; new input lands in skid only while main stalls
  always_comb begin
    main_d       = main_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d  = dec;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    main_d  = main_q;
    valid_d = valid_q;
    if (accept) begin
      main_d  = dec;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (flush) valid_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_alu_ctrl = main_q.alu_ctrl;
  assign out_in1_sel  = main_q.in1_sel;
  assign out_in2_sel  = main_q.in2_sel;
  assign out_imm      = XLEN'(main_q.imm);
  assign out_pc       = XLEN'(main_q.pc);
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_id_alu_ctrl_stage.sv
// Directed bench for id_alu_ctrl_stage: decode vector table plus backpressure,
// flush and reset-while-stalled sequences.
module tb_id_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_imm, out_pc;
  logic [9:0]  out_alu_ctrl;
  logic [1:0]  out_in1_sel, out_in2_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_alu_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_in1_sel(out_in1_sel), .out_in2_sel(out_in2_sel),
    .out_imm(out_imm), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [9:0]  alu;
    logic [1:0]  in1;
    logic [1:0]  in2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_x1(input logic [11:0] k);
    return {k, 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] cur_imm, cur_pc, e, k;
    logic        stalled, fire;
    int          got, sent;
    logic        saw_not_ready;

    vecs[0]  = '{32'h002081B3, 10'h002, 2'd0, 2'd0, 32'h00000000, 1'b1, 1'b0}; // ADD
    vecs[1]  = '{32'h402081B3, 10'h003, 2'd0, 2'd0, 32'h00000000, 1'b1, 1'b0}; // SUB
    vecs[2]  = '{32'h40335293, 10'h050, 2'd0, 2'd1, 32'h00000003, 1'b1, 1'b0}; // SRAI
    vecs[3]  = '{32'h008000EF, 10'h200, 2'd0, 2'd2, 32'h00000008, 1'b1, 1'b0}; // JAL
    vecs[4]  = '{32'h00000000, 10'h000, 2'd0, 2'd0, 32'h00000000, 1'b0, 1'b1}; // zero word
    vecs[5]  = '{32'hFFF00093, 10'h002, 2'd0, 2'd1, 32'hFFFFFFFF, 1'b1, 1'b0}; // ADDI -1
    vecs[6]  = '{32'h12345137, 10'h200, 2'd0, 2'd1, 32'h12345000, 1'b1, 1'b0}; // LUI
    vecs[7]  = '{32'h00001217, 10'h002, 2'd1, 2'd1, 32'h00001000, 1'b1, 1'b0}; // AUIPC
    vecs[8]  = '{32'h0020A223, 10'h002, 2'd0, 2'd1, 32'h00000004, 1'b0, 1'b0}; // SW
    vecs[9]  = '{32'hFE20CEE3, 10'h009, 2'd0, 2'd0, 32'hFFFFFFFC, 1'b0, 1'b0}; // BLT -4
    vecs[10] = '{32'h007362B3, 10'h180, 2'd0, 2'd0, 32'h00000000, 1'b1, 1'b0}; // OR
    vecs[11] = '{32'h40109093, 10'h000, 2'd0, 2'd0, 32'h00000000, 1'b0, 1'b1}; // SLLI bad f7
    vecs[12] = '{32'h00208033, 10'h002, 2'd0, 2'd0, 32'h00000000, 1'b0, 1'b0}; // ADD rd=x0
    vecs[13] = '{32'h000100E7, 10'h200, 2'd0, 2'd2, 32'h00000000, 1'b1, 1'b0}; // JALR
    vecs[14] = '{32'h0010B093, 10'h00D, 2'd0, 2'd1, 32'h00000001, 1'b1, 1'b0}; // SLTIU
    vecs[15] = '{32'h0020F1B3, 10'h100, 2'd0, 2'd0, 32'h00000000, 1'b1, 1'b0}; // AND
    vecs[16] = '{32'h4020D1B3, 10'h050, 2'd0, 2'd0, 32'h00000000, 1'b1, 1'b0}; // SRA

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0;
    step(); step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset alu_ctrl", 32'(out_alu_ctrl), 32'd0);
    chk("reset imm", out_imm, 32'd0);
    chk("reset pc", out_pc, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    // decode table, one instruction per cycle
    for (int i = 0; i < 17; i++) begin
      in_valid  = 1'b1;
      in_inst   = vecs[i].inst;
      in_pc     = 32'h1000 + 32'(i) * 32'd4;
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d alu", i), 32'(out_alu_ctrl), 32'(vecs[i].alu));
      chk($sformatf("v%0d in1", i), 32'(out_in1_sel), 32'(vecs[i].in1));
      chk($sformatf("v%0d in2", i), 32'(out_in2_sel), 32'(vecs[i].in2));
      chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d pc", i), out_pc, 32'h1000 + 32'(i) * 32'd4);
      chk($sformatf("v%0d rs1", i), 32'(out_rs1), 32'(vecs[i].inst[19:15]));
      chk($sformatf("v%0d rs2", i), 32'(out_rs2), 32'(vecs[i].inst[24:20]));
      chk($sformatf("v%0d rd", i), 32'(out_rd), 32'(vecs[i].inst[11:7]));
      chk($sformatf("v%0d rd_we", i), 32'(out_rd_we), 32'(vecs[i].we));
      chk($sformatf("v%0d illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
    end
    in_valid = 1'b0;
    step();
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // backpressure: 4 instructions, out_ready low for 3 cycles
    got = 0; sent = 0; saw_not_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      k         = 32'd16 + 32'(sent);
      in_valid  = (sent < 4);
      in_inst   = addi_x1(k[11:0]);
      in_pc     = 32'h2000 + 32'(sent) * 32'd4;
      out_ready = !(cyc >= 1 && cyc <= 3);
      #1;
      if (!in_ready) saw_not_ready = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(k);
        sent++;
      end
      fire    = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      cur_imm = out_imm;
      cur_pc  = out_pc;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bp spurious: got imm 0x%08h with nothing outstanding", cur_imm);
        end else begin
          e = exp_q.pop_front();
          chk("bp order imm", cur_imm, e);
          got++;
        end
      end
      step();
      if (stalled) begin
        chk("bp hold valid", 32'(out_valid), 32'd1);
        chk("bp hold imm", out_imm, cur_imm);
        chk("bp hold pc", out_pc, cur_pc);
      end
    end
    in_valid = 1'b0;
    chk("bp received", 32'(got), 32'd4);
    chk("bp outstanding", 32'(exp_q.size()), 32'd0);
    chk("bp in_ready dropped", 32'(saw_not_ready), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp empty after", 32'(out_valid), 32'd0);

    // flush with in_valid and out_valid both high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = addi_x1(12'h055);
    step();
    chk("flush preload valid", 32'(out_valid), 32'd1);
    in_inst = addi_x1(12'h066);
    flush   = 1'b1;
    step();
    chk("flush clears valid", 32'(out_valid), 32'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("flush input dropped", 32'(out_valid), 32'd0);

    // reset while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = addi_x1(12'h077);
    step();
    in_inst = addi_x1(12'h078);
    step();
    chk("rst preload valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk("rst stalled valid", 32'(out_valid), 32'd0);
    chk("rst stalled in_ready", 32'(in_ready), 32'd1);
    chk("rst stalled imm", out_imm, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rst no residue", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
